// File: rtl/irq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_sequencer: device IRQ collection, ION delay and hardware JMS 0 entry |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module irq_sequencer #(
  parameter int NDEV   = 4,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              clear,
  input  logic              instDone,
  input  logic              ionSet,
  input  logic              ionClr,
  input  logic [NDEV-1:0]   devIrq,
  input  logic [NDEV-1:0]   devMask,
  input  logic [ADDR_W-1:0] pcIn,
  input  logic              memAck,
  output logic              irqPending,
  output logic              ionFlag,
  output logic              takeover,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [ADDR_W-1:0] memData,
  output logic              pcLoad,
  output logic [ADDR_W-1:0] pcOut,
  output logic [3:0]        irqSrc,
  output logic              irqDone
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAVE   = 2'd1,
    S_VECTOR = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] c_SAVE_ADDR = '0;
  localparam logic [ADDR_W-1:0] c_VECTOR_PC = ADDR_W'(1);

  state_t            r_state, w_next;
  logic              r_ion_flag, r_ion_eff, r_ion_arm;
  logic [ADDR_W-1:0] r_mem_data;
  logic [3:0]        r_irq_src;
  logic [NDEV-1:0]   w_active;
  logic [3:0]        w_src;
  logic              w_entry;

  assign w_active   = devIrq & devMask;
  assign irqPending = |w_active;

  // Descending scan so the lowest active index (highest priority) wins.
  always_comb begin
    w_src = 4'd0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (w_active[i]) w_src = 4'(i);
    end
  end

  // The ~ionSet term enforces the one-instruction delay when ION re-executes.
  assign w_entry = (r_state == S_IDLE) && instDone && r_ion_eff && irqPending && !ionSet;

  always_comb begin
    w_next   = r_state;
    takeover = 1'b0;
    memWe    = 1'b0;
    pcLoad   = 1'b0;
    irqDone  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_entry) w_next = S_SAVE;
      end
      S_SAVE: begin
        takeover = 1'b1;
        memWe    = 1'b1;
        if (memAck) w_next = S_VECTOR;
      end
      S_VECTOR: begin
        takeover = 1'b1;
        pcLoad   = 1'b1;
        w_next   = S_DONE;
      end
      S_DONE: begin
        takeover = 1'b1;
        irqDone  = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_state    <= S_IDLE;
      r_ion_flag <= 1'b0;
      r_ion_eff  <= 1'b0;
      r_ion_arm  <= 1'b0;
      r_mem_data <= '0;
      r_irq_src  <= 4'd0;
    end else begin
      r_state <= w_next;
      if (w_entry) begin
        r_mem_data <= pcIn;
        r_irq_src  <= w_src;
        r_ion_flag <= 1'b0;
        r_ion_eff  <= 1'b0;
        r_ion_arm  <= 1'b0;
      end else if (r_state == S_IDLE) begin
        // Re-arming drops the effective enable, so one more instruction must complete.
        if (ionSet) begin
          r_ion_flag <= 1'b1;
          r_ion_eff  <= 1'b0;
          r_ion_arm  <= 1'b1;
        end else if (ionClr) begin
          r_ion_flag <= 1'b0;
          r_ion_eff  <= 1'b0;
          r_ion_arm  <= 1'b0;
        end else if (instDone && r_ion_arm) begin
          r_ion_eff <= 1'b1;
          r_ion_arm <= 1'b0;
        end
      end
    end
  end

  assign ionFlag = r_ion_flag;
  assign memData = r_mem_data;
  assign irqSrc  = r_irq_src;
  assign memAddr = c_SAVE_ADDR;
  assign pcOut   = c_VECTOR_PC;

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_irq_sequencer: directed vector table plus reset-abort sequence        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_irq_sequencer;

  logic        CLK = 1'b0;
  logic        clear, instDone, ionSet, ionClr, memAck;
  logic [3:0]  devIrq, devMask;
  logic [11:0] pcIn;
  logic        irqPending, ionFlag, takeover, memWe, pcLoad, irqDone;
  logic [11:0] memAddr, memData, pcOut;
  logic [3:0]  irqSrc;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  irq_sequencer #(.NDEV(4), .ADDR_W(12)) dut (
    .CLK(CLK), .clear(clear), .instDone(instDone), .ionSet(ionSet), .ionClr(ionClr),
    .devIrq(devIrq), .devMask(devMask), .pcIn(pcIn), .memAck(memAck),
    .irqPending(irqPending), .ionFlag(ionFlag), .takeover(takeover), .memWe(memWe),
    .memAddr(memAddr), .memData(memData), .pcLoad(pcLoad), .pcOut(pcOut),
    .irqSrc(irqSrc), .irqDone(irqDone)
  );

  typedef struct {
    logic        clr_in, inst, set, iclr;
    logic [3:0]  irq, mask;
    logic [11:0] pc;
    logic        ack;
    logic        e_pend, e_flag, e_to, e_we, e_pl, e_dn;
    logic [11:0] e_md;
    logic [3:0]  e_src;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic c, i, s, ic, input logic [3:0] irq, mask,
                     input logic [11:0] pc, input logic ack,
                     input logic pend, flag, to, we, pl, dn,
                     input logic [11:0] md, input logic [3:0] src);
    vec_t v;
    v.clr_in = c; v.inst = i; v.set = s; v.iclr = ic;
    v.irq = irq; v.mask = mask; v.pc = pc; v.ack = ack;
    v.e_pend = pend; v.e_flag = flag; v.e_to = to; v.e_we = we;
    v.e_pl = pl; v.e_dn = dn; v.e_md = md; v.e_src = src;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic c, i, s, ic, input logic [3:0] irq, mask,
                       input logic [11:0] pc, input logic ack);
    clear = c; instDone = i; ionSet = s; ionClr = ic;
    devIrq = irq; devMask = mask; pcIn = pc; memAck = ack;
  endtask

  initial begin
    drive(1, 0, 0, 0, 4'b0000, 4'b0000, 12'o0000, 0);

    //   clr i s c irq      mask     pc        ack  pnd flg to we pl dn md        src
    // reset
    add(1, 0,0,0, 4'b0000, 4'b0000, 12'o0000, 0,   0,  0,  0, 0, 0, 0, 12'o0000, 4'd0);
    add(1, 0,0,0, 4'b0001, 4'b1111, 12'o0000, 0,   1,  0,  0, 0, 0, 0, 12'o0000, 4'd0);
    // ION delay: ION with its own instDone, then one more instruction before entry
    add(0, 1,1,0, 4'b0001, 4'b1111, 12'o0100, 0,   1,  1,  0, 0, 0, 0, 12'o0000, 4'd0);
    add(0, 0,0,0, 4'b0001, 4'b1111, 12'o0100, 0,   1,  1,  0, 0, 0, 0, 12'o0000, 4'd0);
    add(0, 1,0,0, 4'b0001, 4'b1111, 12'o0150, 0,   1,  1,  0, 0, 0, 0, 12'o0000, 4'd0);
    add(0, 1,0,0, 4'b0001, 4'b1111, 12'o0200, 0,   1,  0,  1, 1, 0, 0, 12'o0200, 4'd0);
    // SAVE held three cycles by late memAck; request drops mid-sequence
    add(0, 0,0,0, 4'b0001, 4'b1111, 12'o0000, 0,   1,  0,  1, 1, 0, 0, 12'o0200, 4'd0);
    add(0, 1,1,0, 4'b0000, 4'b1111, 12'o0000, 0,   0,  0,  1, 1, 0, 0, 12'o0200, 4'd0);
    add(0, 0,0,0, 4'b0000, 4'b1111, 12'o0000, 1,   0,  0,  1, 0, 1, 0, 12'o0200, 4'd0);
    add(0, 0,0,0, 4'b0000, 4'b1111, 12'o0000, 0,   0,  0,  1, 0, 0, 1, 12'o0200, 4'd0);
    add(0, 0,0,0, 4'b0000, 4'b1111, 12'o0000, 0,   0,  0,  0, 0, 0, 0, 12'o0200, 4'd0);
    // priority: 1010 with full mask -> device 1
    add(0, 0,1,0, 4'b1010, 4'b1111, 12'o0000, 0,   1,  1,  0, 0, 0, 0, 12'o0200, 4'd0);
    add(0, 1,0,0, 4'b1010, 4'b1111, 12'o0000, 0,   1,  1,  0, 0, 0, 0, 12'o0200, 4'd0);
    add(0, 1,0,0, 4'b1010, 4'b1111, 12'o0300, 0,   1,  0,  1, 1, 0, 0, 12'o0300, 4'd1);
    add(0, 0,0,0, 4'b1010, 4'b1111, 12'o0000, 1,   1,  0,  1, 0, 1, 0, 12'o0300, 4'd1);
    add(0, 0,0,0, 4'b1010, 4'b1111, 12'o0000, 0,   1,  0,  1, 0, 0, 1, 12'o0300, 4'd1);
    add(0, 0,0,0, 4'b1010, 4'b1111, 12'o0000, 0,   1,  0,  0, 0, 0, 0, 12'o0300, 4'd1);
    // mask 1101 hides device 1 -> device 3
    add(0, 0,1,0, 4'b1010, 4'b1101, 12'o0000, 0,   1,  1,  0, 0, 0, 0, 12'o0300, 4'd1);
    add(0, 1,0,0, 4'b1010, 4'b1101, 12'o0000, 0,   1,  1,  0, 0, 0, 0, 12'o0300, 4'd1);
    add(0, 1,0,0, 4'b1010, 4'b1101, 12'o0400, 0,   1,  0,  1, 1, 0, 0, 12'o0400, 4'd3);
    add(0, 0,0,0, 4'b1010, 4'b1101, 12'o0000, 1,   1,  0,  1, 0, 1, 0, 12'o0400, 4'd3);
    add(0, 0,0,0, 4'b1010, 4'b1101, 12'o0000, 0,   1,  0,  1, 0, 0, 1, 12'o0400, 4'd3);
    add(0, 0,0,0, 4'b1010, 4'b1101, 12'o0000, 0,   1,  0,  0, 0, 0, 0, 12'o0400, 4'd3);
    // all masked: nothing pending, no entry even with ION effective
    add(0, 0,1,0, 4'b1010, 4'b0000, 12'o0000, 0,   0,  1,  0, 0, 0, 0, 12'o0400, 4'd3);
    add(0, 1,0,0, 4'b1010, 4'b0000, 12'o0000, 0,   0,  1,  0, 0, 0, 0, 12'o0400, 4'd3);
    add(0, 1,0,0, 4'b1010, 4'b0000, 12'o0500, 0,   0,  1,  0, 0, 0, 0, 12'o0400, 4'd3);
    // ionClr, then set+clr together (set wins), then clear after arming
    add(0, 0,0,1, 4'b0001, 4'b1111, 12'o0000, 0,   1,  0,  0, 0, 0, 0, 12'o0400, 4'd3);
    add(0, 0,1,1, 4'b0001, 4'b1111, 12'o0000, 0,   1,  1,  0, 0, 0, 0, 12'o0400, 4'd3);
    add(0, 0,0,1, 4'b0001, 4'b1111, 12'o0000, 0,   1,  0,  0, 0, 0, 0, 12'o0400, 4'd3);
    add(0, 1,0,0, 4'b0001, 4'b1111, 12'o0600, 0,   1,  0,  0, 0, 0, 0, 12'o0400, 4'd3);
    add(0, 1,0,0, 4'b0001, 4'b1111, 12'o0610, 0,   1,  0,  0, 0, 0, 0, 12'o0400, 4'd3);
    // PC 7777 saved unchanged; memAck in first SAVE cycle
    add(0, 0,1,0, 4'b0001, 4'b1111, 12'o0000, 0,   1,  1,  0, 0, 0, 0, 12'o0400, 4'd3);
    add(0, 1,0,0, 4'b0001, 4'b1111, 12'o0000, 0,   1,  1,  0, 0, 0, 0, 12'o0400, 4'd3);
    add(0, 1,0,0, 4'b0001, 4'b1111, 12'o7777, 0,   1,  0,  1, 1, 0, 0, 12'o7777, 4'd0);
    add(0, 0,0,0, 4'b0001, 4'b1111, 12'o0000, 1,   1,  0,  1, 0, 1, 0, 12'o7777, 4'd0);
    add(0, 0,0,0, 4'b0001, 4'b1111, 12'o0000, 0,   1,  0,  1, 0, 0, 1, 12'o7777, 4'd0);
    add(0, 0,0,0, 4'b0001, 4'b1111, 12'o0000, 0,   1,  0,  0, 0, 0, 0, 12'o7777, 4'd0);

    for (int n = 0; n < vecs.size(); n++) begin
      vec_t v;
      v = vecs[n];
      drive(v.clr_in, v.inst, v.set, v.iclr, v.irq, v.mask, v.pc, v.ack);
      tick();
      chk($sformatf("v%0d irqPending", n), 32'(irqPending), 32'(v.e_pend));
      chk($sformatf("v%0d ionFlag", n),    32'(ionFlag),    32'(v.e_flag));
      chk($sformatf("v%0d takeover", n),   32'(takeover),   32'(v.e_to));
      chk($sformatf("v%0d memWe", n),      32'(memWe),      32'(v.e_we));
      chk($sformatf("v%0d pcLoad", n),     32'(pcLoad),     32'(v.e_pl));
      chk($sformatf("v%0d irqDone", n),    32'(irqDone),    32'(v.e_dn));
      chk($sformatf("v%0d memData", n),    32'(memData),    32'(v.e_md));
      chk($sformatf("v%0d irqSrc", n),     32'(irqSrc),     32'(v.e_src));
      chk($sformatf("v%0d memAddr", n),    32'(memAddr),    32'd0);
      chk($sformatf("v%0d pcOut", n),      32'(pcOut),      32'd1);
    end

    // Reset held two cycles in the middle of SAVE aborts the sequence
    drive(0, 0, 1, 0, 4'b0100, 4'b1111, 12'o0000, 0); tick();
    drive(0, 1, 0, 0, 4'b0100, 4'b1111, 12'o0000, 0); tick();
    drive(0, 1, 0, 0, 4'b0100, 4'b1111, 12'o1234, 0); tick();
    chk("t1 entered SAVE", 32'(memWe), 32'd1);
    chk("t1 memData", 32'(memData), 32'o1234);
    chk("t1 irqSrc", 32'(irqSrc), 32'd2);
    drive(1, 0, 0, 0, 4'b0100, 4'b1111, 12'o0000, 0); tick();
    chk("t1 memWe in reset", 32'(memWe), 32'd0);
    chk("t1 takeover in reset", 32'(takeover), 32'd0);
    drive(1, 0, 0, 0, 4'b0100, 4'b1111, 12'o0000, 1); tick();
    chk("t1 ionFlag in reset", 32'(ionFlag), 32'd0);
    chk("t1 memData cleared", 32'(memData), 32'd0);
    chk("t1 irqSrc cleared", 32'(irqSrc), 32'd0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 4'b0100, 4'b1111, 12'o0000, 1); tick();
      chk($sformatf("t1 no pcLoad c%0d", k), 32'(pcLoad), 32'd0);
      chk($sformatf("t1 idle c%0d", k), 32'(takeover), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
